i2s_tx_serializer: RTL and testbench

I2S_TX_SERIALIZER -- requirements
Module: i2s_tx_serializer

---
 rtl/i2s_tx_serializer.sv | 146 ++++++++++++++
 tb/tb_i2s_tx_serializer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: small sample FIFO feeding a 64-bit-per-frame serializer.
// Each frame sends one sample duplicated into the left and right slots, MSB first.
module i2s_tx_serializer #(
   parameter int WD_IN      = 24,
   parameter int BCLK_DIV   = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          sample_clock,
   input  logic                          reset,
   input  logic [WD_IN-1:0]              input_sample,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          bclk,
   output logic                          lrclk,
   output logic                          sdata,
   output logic                          underrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int DW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
   localparam int IW = $clog2(WD_IN);
   localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_DIV - 1);
   localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

   logic [DW-1:0]              div_cnt_q, div_cnt_d;
   logic                       bclk_q, bclk_d;
   logic [5:0]                 bit_cnt_q, bit_cnt_d;
   logic                       lrclk_q, lrclk_d;
   logic                       sdata_q, sdata_d;
   logic                       underrun_q, underrun_d;
   logic signed [WD_IN-1:0]    shadow_q, shadow_d;
   logic signed [WD_IN-1:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]              level_q, level_d;

   logic fall;
   logic frame_start;
   logic push;
   logic pop;
   logic fifo_empty;

   // Slot bit p (1..WD_IN) carries word[WD_IN-p]; slot 0 and the tail pad are zero.
   function automatic logic slot_bit(input logic signed [WD_IN-1:0] word,
                                     input logic [4:0] p);
      int pos;
      logic [IW-1:0] idx;
      pos = int'(p);
      slot_bit = 1'b0;
      idx = '0;
      if (pos >= 1 && pos <= WD_IN) begin
         idx = IW'(WD_IN - pos);
         slot_bit = word[idx];
      end
   endfunction

   assign fifo_empty  = (level_q == '0);
   assign in_ready    = (level_q != LVL_FULL);
   assign push        = in_valid && in_ready;
   assign fall        = (div_cnt_q == DIV_MAX) && bclk_q;
   assign frame_start = fall && (bit_cnt_q == 6'd63);
   // A same-cycle push never feeds the pop: emptiness is judged on the old level.
   assign pop         = frame_start && !fifo_empty;

   always_comb begin
      div_cnt_d  = div_cnt_q + DW'(1);
      bclk_d     = bclk_q;
      bit_cnt_d  = bit_cnt_q;
      lrclk_d    = lrclk_q;
      sdata_d    = sdata_q;
      underrun_d = 1'b0;
      shadow_d   = shadow_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;

      if (div_cnt_q == DIV_MAX) begin
         div_cnt_d = '0;
         bclk_d    = ~bclk_q;
      end

      if (fall) begin
         bit_cnt_d = bit_cnt_q + 6'd1;
         lrclk_d   = bit_cnt_d[5];
         sdata_d   = slot_bit(shadow_q, bit_cnt_d[4:0]);
      end

      if (frame_start) begin
         if (fifo_empty) begin
            shadow_d   = '0;
            underrun_d = 1'b1;
         end else begin
            shadow_d = mem_q[rd_ptr_q];
         end
      end

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge sample_clock) begin
      if (reset) begin
         div_cnt_q  <= '0;
         bclk_q     <= 1'b0;
         bit_cnt_q  <= 6'd63;
         lrclk_q    <= 1'b0;
         sdata_q    <= 1'b0;
         underrun_q <= 1'b0;
         shadow_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
      end else begin
         div_cnt_q  <= div_cnt_d;
         bclk_q     <= bclk_d;
         bit_cnt_q  <= bit_cnt_d;
         lrclk_q    <= lrclk_d;
         sdata_q    <= sdata_d;
         underrun_q <= underrun_d;
         shadow_q   <= shadow_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers and level.
   always_ff @(posedge sample_clock) begin
      if (push) mem_q[wr_ptr_q] <= input_sample;
   end

   assign bclk       = bclk_q;
   assign lrclk      = lrclk_q;
   assign sdata      = sdata_q;
   assign underrun   = underrun_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: an independent slot decoder rebuilds
// each transmitted word and the tests compare them with hand-written values.
module tb_i2s_tx_serializer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [23:0] input_sample = '0;
   logic        in_ready, bclk, lrclk, sdata, underrun;
   logic [2:0]  fifo_level;

   i2s_tx_serializer #(.WD_IN(24), .BCLK_DIV(4), .FIFO_DEPTH(4)) dut (
      .sample_clock (clk),
      .reset        (reset),
      .input_sample (input_sample),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .bclk         (bclk),
      .lrclk        (lrclk),
      .sdata        (sdata),
      .underrun     (underrun),
      .fifo_level   (fifo_level)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Decoder state, sampled 1 time unit after each rising edge.
   int          rel = 0;
   int          tk = 63;
   int          p;
   int          max_lvl = 0;
   bit          seen_one = 0;
   bit          fell;
   logic        prev_bclk = 1'b0;
   logic [23:0] word = '0;
   logic [23:0] cap_l[$];
   logic [23:0] cap_r[$];
   int          ur_t[$];

   always @(posedge clk) begin
      #1;
      if (reset) begin
         rel = 0; tk = 63; prev_bclk = 1'b0; word = '0; max_lvl = 0;
      end else begin
         rel++;
         if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
         if (sdata) seen_one = 1;
         fell = prev_bclk && !bclk;
         if (fell) begin
            tk = (tk + 1) % 64;
            chk("lrclk_slot", lrclk, (tk >= 32) ? 1 : 0);
            p = tk % 32;
            if (p >= 1 && p <= 24) begin
               word = {word[22:0], sdata};
               if (p == 24) begin
                  if (tk < 32) cap_l.push_back(word);
                  else         cap_r.push_back(word);
               end
            end else begin
               chk("sdata_pad_zero", sdata, 0);
            end
         end
         if (underrun) begin
            ur_t.push_back(rel);
            chk("underrun_at_frame_start", (fell && tk == 0) ? 1 : 0, 1);
         end
         prev_bclk = bclk;
      end
   end

   typedef struct {
      logic [23:0] din;
      logic [23:0] exp;
   } vec_t;
   vec_t vt[26];

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b0; input_sample = '0;
      repeat (3) @(negedge clk);
      cap_l.delete(); cap_r.delete(); ur_t.delete(); seen_one = 0;
      reset = 1'b0;
   endtask

   // Called at a negedge; holds in_valid until accepted and returns at the next negedge.
   task automatic push(input logic [23:0] s, input bit keep, output int t);
      int n;
      n = 0; t = -1;
      in_valid = 1'b1; input_sample = s;
      while (t < 0 && n < 3000) begin
         if (in_ready) begin
            @(posedge clk); #2;
            t = rel;
         end
         @(negedge clk);
         n++;
      end
      if (t < 0) chk("push_timeout", 0, 1);
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic wait_caps(input int n);
      int b;
      b = 0;
      while (cap_r.size() < n && b < 20000) begin @(negedge clk); b++; end
      chk("capture_count", cap_r.size(), n);
   endtask

   task automatic wait_rel(input int r);
      int b;
      b = 0;
      while (rel < r && b < 20000) begin @(negedge clk); b++; end
      chk("wait_rel", rel, r);
   endtask

   task automatic wait_level0();
      int b;
      b = 0;
      while (fifo_level != 0 && b < 2000) begin @(negedge clk); b++; end
      chk("wait_level0", fifo_level, 0);
   endtask

   initial begin
      int t;
      int ta[6];
      logic [23:0] s6[6];
      logic [23:0] abcd[4];
      int b;

      vt[0] = '{24'hA5F00F, 24'b101001011111000000001111};
      vt[1] = '{24'h800000, 24'h800000};
      vt[2] = '{24'h7FFFFF, 24'h7FFFFF};
      vt[3] = '{24'hFFFFFF, 24'hFFFFFF};
      vt[4] = '{24'h000001, 24'h000001};
      vt[5] = '{24'h5A0FF0, 24'h5A0FF0};
      for (int i = 0; i < 20; i++) vt[6 + i] = '{24'(i + 1), 24'(i + 1)};

      // Reset state
      do_reset();
      chk("rst_bclk", bclk, 0);
      chk("rst_lrclk", lrclk, 0);
      chk("rst_sdata", sdata, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_in_ready", in_ready, 1);

      // Single sample
      push(24'hA5F00F, 0, t);
      chk("single_accept_cycle", t, 1);
      wait_caps(1);
      chk("single_left", cap_l.size() > 0 ? cap_l[0] : 24'h0, 24'b101001011111000000001111);
      chk("single_right", cap_r[0], 24'b101001011111000000001111);
      chk("single_no_underrun", ur_t.size(), 0);

      // Empty start
      do_reset();
      wait_rel(1040);
      chk("empty_ur_count", ur_t.size(), 3);
      for (int i = 0; i < 3; i++)
         chk("empty_ur_time", (i < ur_t.size()) ? ur_t[i] : -1, 8 + 512 * i);
      chk("empty_sdata_quiet", seen_one, 0);

      // Table-driven stream, one sample per frame, including pointer wrap
      do_reset();
      push(vt[0].din, 0, t);
      for (int i = 1; i < 26; i++) begin
         wait_level0();
         push(vt[i].din, 0, t);
      end
      wait_caps(26);
      for (int i = 0; i < 26; i++) begin
         chk("stream_left", (i < cap_l.size()) ? cap_l[i] : 24'hx, vt[i].exp);
         chk("stream_right", (i < cap_r.size()) ? cap_r[i] : 24'hx, vt[i].exp);
      end
      chk("stream_no_underrun", ur_t.size(), 0);
      chk("stream_max_level", max_lvl, 1);

      // Overflow with in_valid held high
      do_reset();
      s6 = '{24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555, 24'h666666};
      for (int i = 0; i < 6; i++) begin
         push(s6[i], 1, ta[i]);
         if (i == 3) begin
            chk("ovf_level_full", fifo_level, 4);
            chk("ovf_in_ready_low", in_ready, 0);
         end
      end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) chk("ovf_accept_cycle", ta[i], i + 1);
      chk("ovf_fifth_accept", ta[4], 9);
      chk("ovf_sixth_accept", ta[5], 521);
      wait_caps(6);
      for (int i = 0; i < 6; i++) begin
         chk("ovf_left_order", (i < cap_l.size()) ? cap_l[i] : 24'hx, s6[i]);
         chk("ovf_right_order", (i < cap_r.size()) ? cap_r[i] : 24'hx, s6[i]);
      end

      // Push and pop in the same frame-start cycle at level 2
      do_reset();
      abcd = '{24'hA00001, 24'hB00002, 24'hC00003, 24'hD00004};
      for (int i = 0; i < 3; i++) push(abcd[i], 0, t);
      wait_rel(519);
      chk("simul_level_before", fifo_level, 2);
      push(abcd[3], 0, t);
      chk("simul_accept_cycle", t, 520);
      chk("simul_level_after", fifo_level, 2);
      wait_caps(4);
      for (int i = 0; i < 4; i++)
         chk("simul_order", (i < cap_l.size()) ? cap_l[i] : 24'hx, abcd[i]);
      chk("simul_no_underrun", ur_t.size(), 0);

      // Push into an empty FIFO on the frame-start cycle does not bypass
      do_reset();
      wait_rel(7);
      push(24'h3C3C3C, 0, t);
      chk("nobypass_accept", t, 8);
      chk("nobypass_level", fifo_level, 1);
      chk("nobypass_ur", (ur_t.size() > 0) ? ur_t[0] : -1, 8);
      wait_caps(2);
      chk("nobypass_frame0", cap_l[0], 24'h0);
      chk("nobypass_frame1", cap_l[1], 24'h3C3C3C);

      // Reset in the middle of the right slot with three samples queued
      do_reset();
      for (int i = 0; i < 4; i++) push(s6[i], 0, t);
      b = 0;
      while (tk != 40 && b < 2000) begin @(negedge clk); b++; end
      chk("midrst_bitcnt", tk, 40);
      chk("midrst_level", fifo_level, 3);
      chk("midrst_lrclk_pre", lrclk, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_bclk", bclk, 0);
      chk("midrst_lrclk", lrclk, 0);
      chk("midrst_sdata", sdata, 0);
      chk("midrst_underrun", underrun, 0);
      chk("midrst_level_clr", fifo_level, 0);
      chk("midrst_in_ready", in_ready, 1);
      cap_l.delete(); cap_r.delete(); ur_t.delete();
      reset = 1'b0;
      wait_caps(1);
      chk("midrst_first_ur", (ur_t.size() > 0) ? ur_t[0] : -1, 8);
      chk("midrst_left_zero", cap_l[0], 24'h0);
      chk("midrst_right_zero", cap_r[0], 24'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
